// File: rtl/vga_scan_gen_if.sv
// Scan-timing bundle from vga_scan_gen to the cell-matrix renderer.
interface vga_scan_gen_if;
  logic       pix_en;
  logic [9:0] VGAx;
  logic [9:0] VGAy;
  logic       display_on;
  logic       hsync;
  logic       vsync;
  logic       frame_start;
  logic       gen_tick;

  modport master (
    output pix_en, VGAx, VGAy, display_on,
    output hsync, vsync, frame_start, gen_tick
  );

  modport slave (
    input pix_en, VGAx, VGAy, display_on,
    input hsync, vsync, frame_start, gen_tick
  );
endinterface

// File: rtl/vga_scan_gen.sv
// 640x480@60 pixel-slot divider, scan counters and registered decode.
// Define VGA_SCAN_GEN_TICK_EN to build the per-GEN_FRAMES generation tick.
module vga_scan_gen #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_POL   = 0,
  parameter int GEN_FRAMES = 8
) (
  input logic      clk,
  input logic      rst_n,
  vga_scan_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] HV   = 10'(H_VISIBLE);
  localparam logic [9:0] HS_B = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_E = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] VV   = 10'(V_VISIBLE);
  localparam logic [9:0] VS_B = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_E = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic ACT = (SYNC_POL != 0);

  logic [DW-1:0] div;
  logic          pix_en;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;

  logic       d_on;
  logic       d_hs;
  logic       d_vs;
  logic       d_org;
  logic [9:0] d_x;
  logic [9:0] d_y;

  logic [9:0] q_x;
  logic [9:0] q_y;
  logic       q_on;
  logic       q_hs;
  logic       q_vs;
  logic       q_fs;
  logic       tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    d_on  = (h_cnt < HV) && (v_cnt < VV);
    d_x   = d_on ? h_cnt : '0;
    d_y   = d_on ? v_cnt : '0;
    d_hs  = (h_cnt >= HS_B && h_cnt < HS_E) ? ACT : ~ACT;
    d_vs  = (v_cnt >= VS_B && v_cnt < VS_E) ? ACT : ~ACT;
    d_org = (h_cnt == '0) && (v_cnt == '0);
  end

  // frame_start drops on the very next clk, not the next slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_x  <= '0;
      q_y  <= '0;
      q_on <= 1'b0;
      q_hs <= ~ACT;
      q_vs <= ~ACT;
      q_fs <= 1'b0;
    end else begin
      q_fs <= pix_en && d_org;
      if (pix_en) begin
        q_x  <= d_x;
        q_y  <= d_y;
        q_on <= d_on;
        q_hs <= d_hs;
        q_vs <= d_vs;
      end
    end
  end

`ifdef VGA_SCAN_GEN_TICK_EN
  localparam int FW = (GEN_FRAMES > 1) ? $clog2(GEN_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(GEN_FRAMES - 1);

  logic [FW-1:0] fcnt;
  logic          vb_start;

  assign vb_start = pix_en && (h_cnt == '0) && (v_cnt == VV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (vb_start) begin
        if (fcnt == F_LAST) begin
          fcnt <= '0;
          tick <= 1'b1;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end
`else
  assign tick = 1'b0;
`endif

  assign vga.pix_en      = pix_en;
  assign vga.VGAx        = q_x;
  assign vga.VGAy        = q_y;
  assign vga.display_on  = q_on;
  assign vga.hsync       = q_hs;
  assign vga.vsync       = q_vs;
  assign vga.frame_start = q_fs;
  assign vga.gen_tick    = tick;

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Pixel-timing generator that sits directly upstream of the cell-matrix renderer.
- Divides the system clock into a pixel-slot enable and runs the horizontal and vertical scan counters for 640x480@60.
- Produces the VGAx/VGAy coordinates the renderer indexes with, plus hsync/vsync, a display-active flag and a frame-start pulse.
- Optionally produces a generation tick that tells the life engine when to compute the next generation.

Parameters:
- CLK_DIV, 2, system clocks per pixel slot (>=1).
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- SYNC_POL, 0, active level of hsync and vsync (0 = active-low).
- GEN_FRAMES, 8, frames per generation tick (>=1; used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- pix_en  out  1  one-clk pulse per pixel slot.
- VGAx  out  10  current column; 0 outside the active area.
- VGAy  out  10  current row; 0 outside the active area.
- display_on  out  1  high when (VGAx,VGAy) is inside the active area.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- frame_start  out  1  one-clk pulse when pixel (0,0) is presented.
- gen_tick  out  1  one-clk generation pulse (optional feature).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Reset values:
  - div, h_cnt, v_cnt = 0.
  - pix_en, VGAx, VGAy, display_on, frame_start, gen_tick = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en is registered and is high for exactly the one clk in which div == CLK_DIV-1.
  - CLK_DIV=1 makes pix_en permanently high after the first clk edge following reset release.
- Scan counters:
  - On each clk edge with pix_en high, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 only when h_cnt also wraps.
- Output register stage:
  - On the same pix_en edge, all outputs load the decode of the pre-increment (h_cnt,v_cnt).
  - Outputs therefore lag the counters by exactly one pixel slot and are mutually aligned.
  - Outputs hold between pix_en edges.
- Decode:
  - display_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
  - VGAx = h_cnt and VGAy = v_cnt when display_on, else both 0.
  - hsync = SYNC_POL while H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751), else ~SYNC_POL.
  - vsync = SYNC_POL while V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), else ~SYNC_POL.
  - vsync depends on line only; it is not pixel-aligned within the line.
- frame_start:
  - Loaded high on the pix_en edge that presents (0,0).
  - Cleared on the next clk edge, so it is one clk wide even when CLK_DIV > 1.
- First output after reset release: the CLK_DIV-th rising edge presents (0,0) with display_on=1 and frame_start=1.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); the scan restarts at (0,0) as above. No partial-frame state survives.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clks (840000 at defaults).

Optional Feature:
- Macro: VGA_SCAN_GEN_TICK_EN.
- Defined:
  - A frame counter fcnt runs 0..GEN_FRAMES-1 and resets to 0.
  - fcnt increments on the pix_en edge presenting h_cnt=0, v_cnt=V_VISIBLE (start of vertical blanking).
  - On that same edge, if fcnt == GEN_FRAMES-1, gen_tick loads 1 (cleared the next clk) and fcnt wraps to 0.
  - The first tick follows the visible area of frame GEN_FRAMES-1, counting frames from 0.
  - With GEN_FRAMES=1, gen_tick fires every frame.
- Not defined: gen_tick is tied 0 and no frame counter is built.

Test Plan:
- Reset release, CLK_DIV=2: pix_en first high on clk edge 1 (0-indexed); edge 2 presents VGAx=0, VGAy=0, display_on=1, frame_start=1; frame_start=0 on edge 3.
- Full line, defaults: over 800 pix_en pulses, display_on high for 640, hsync low for exactly 96 consecutive slots starting at slot 656, VGAx runs 0..639 then reads 0.
- Full frame, defaults: vsync low for exactly 2 lines (rows 490,491); frame_start pulses exactly 840000 clks apart; VGAy maxes at 479.
- Assert rst_n low mid-line at h_cnt=300, v_cnt=100: all outputs at reset values in the same cycle; after release, (0,0) and frame_start reappear after CLK_DIV edges.
- CLK_DIV=1, SYNC_POL=1: pix_en constantly high; hsync high 656..751; line length 800 clks.
- VGA_SCAN_GEN_TICK_EN defined, GEN_FRAMES=3: gen_tick pulses one clk at the (0,480) slot of frames 2, 5, 8; never during display_on. Macro undefined: gen_tick stays 0.
